iob_wb_bridge: RTL and testbench
================================

// Module: iob_wb_bridge
// PURPOSE
//  Parametrised IOb-native slave to Wishbone master bridge. It is the generic successor of the
//  ad-hoc IOb-to-Wishbone glue used around the Ethernet MAC register port.
//  Adds a request buffer, classic or pipelined (B4) Wishbone modes, a bus-timeout watchdog and
//  error responses. Sits between the CPU IOb interconnect and any Wishbone register-slave peripheral.
// PARAMETERS
//  ADDR_W      12  IOb byte-address width
//  DATA_W      32  data width; multiple of 8
//  WB_LSB       2  address LSBs dropped: wb_adr_o = s_addr[ADDR_W-1:WB_LSB]
//  REQ_DEPTH    2  request buffer entries; power of two, >=1
//  PIPELINED    0  0 = Wishbone classic; 1 = B4 pipelined (honours wb_stall_i)
//  TIMEOUT    255  cycles waiting for ack/err before aborting; 0 disables the watchdog
// PORTS
//  clk          in   1            clock; all logic is rising-edge
//  rst_n        in   1            asynchronous active-low reset
//  s_valid      in   1            request valid; held stable until s_ready
//  s_addr       in   ADDR_W       byte address
//  s_wdata      in   DATA_W       write data
//  s_wstrb      in   DATA_W/8     byte strobes; all zero = read
//  s_ready      out  1            request accepted this cycle (s_valid & s_ready)
//  s_rvalid     out  1            one-cycle response pulse; exactly one per accepted request
//  s_rdata      out  DATA_W       read data, valid with s_rvalid; 0 for writes and errors
//  s_rerr       out  1            response is bus error or timeout, valid with s_rvalid
//  wb_adr_o     out  ADDR_W-WB_LSB  word address
//  wb_dat_o     out  DATA_W       write data
//  wb_sel_o     out  DATA_W/8     s_wstrb for writes; all ones for reads
//  wb_we_o      out  1            write enable (|wstrb)
//  wb_cyc_o     out  1            cycle
//  wb_stb_o     out  1            strobe
//  wb_dat_i     in   DATA_W       read data
//  wb_ack_i     in   1            acknowledge
//  wb_err_i     in   1            error termination
//  wb_stall_i   in   1            pipelined stall; ignored when PIPELINED=0
//  timeout_o    out  1            one-cycle pulse when the watchdog aborts a cycle
// BEHAVIOUR
//  Reset: all outputs 0; buffer empty; FSM in IDLE; watchdog counter 0.
//  s_ready = !full, registered. It does not depend on a same-cycle pop, so no combinational
//   path exists from s_valid or Wishbone inputs.
//  Accepted request {addr,wdata,wstrb} is pushed into the buffer. Only one Wishbone cycle is
//   outstanding at a time. Responses are returned in order.
//  FSM IDLE: buffer non-empty -> ISSUE. Registered outputs present the head entry,
//   cyc=stb=1 in the next cycle. Minimum latency: accept at T, stb at T+1, ack at T+1,
//   s_rvalid at T+2.
//  ISSUE, classic: stb is held until termination.
//  ISSUE, pipelined: stb drops in the first cycle with stb & !wb_stall_i, then -> WAIT with
//   cyc still 1. Termination may arrive in the same cycle as the stb handshake.
//  Termination, ack or err: cyc=stb=0 next cycle; pop head; s_rvalid=1 for one cycle with
//   s_rdata=wb_dat_i on a read ack, s_rerr=wb_err_i; FSM -> IDLE. A back-to-back request
//   re-issues the cycle after.
//  ack and err in the same cycle: err wins (s_rerr=1, s_rdata=0).
//  Watchdog: counts cycles with cyc=1. On reaching TIMEOUT with no termination in that
//   cycle: abort (cyc=stb=0), pop, s_rvalid=1, s_rerr=1, timeout_o=1.
//   If ack arrives in the expiry cycle, ack wins and timeout_o stays 0.
//  ack/err/stall while cyc=0 are ignored; a late ack after timeout never yields a response.
//  Full buffer: s_ready=0; s_valid must be held; nothing is lost or duplicated.
//  Reset mid-cycle: cyc/stb drop asynchronously; pending requests are discarded; no response.
//  Pointers are log2(REQ_DEPTH)+1 bits wide and wrap modulo 2*REQ_DEPTH.
//   full  = MSBs differ and low bits equal.
// STRUCTURE
//  Package iob_wb_bridge_pkg: FSM state encoding (IDLE, ISSUE, WAIT), request-entry width
//   constant (ADDR_W+DATA_W+DATA_W/8), clog2 helper.
//  Sub-module iob_wb_req_fifo: register-based synchronous FIFO with push, pop, full, empty and
//   head data, async active-low reset. All other logic is in this module.
// TESTING
//  1 Classic read, addr 0x010, slave acks after 3 wait cycles with 0xDEADBEEF:
//    wb_adr_o=0x004, wb_sel_o=0xF, s_rvalid one cycle, s_rdata=0xDEADBEEF, s_rerr=0.
//  2 Write 0x12345678 with wstrb=0x3, zero-wait ack:
//    wb_we_o=1, wb_sel_o=0x3, s_rvalid at T+2, s_rdata=0.
//  3 REQ_DEPTH=2: four back-to-back requests with slave stalling 10 cycles:
//    s_ready low after 2 accepts; all four complete in order, 4 responses, no extra cycles.
//  4 PIPELINED=1: wb_stall_i high 2 cycles, then ack 2 cycles after the stb handshake:
//    stb drops after handshake, cyc held, a single response.
//  5 TIMEOUT=16, slave never answers: cyc high 16 cycles, then timeout_o=1, s_rerr=1;
//    a late ack is ignored.
//  6 Simultaneous ack+err gives s_rerr=1. rst_n low during a cycle: cyc=0 immediately,
//    s_rvalid never asserts, s_ready=1 after release.

Source files
------------

// File: rtl/iob_wb_bridge_pkg.sv
// Shared definitions for the IOb-to-Wishbone bridge.
//  - state_t     : bridge FSM encoding (IDLE, ISSUE, WAIT)
//  - clog2       : ceiling log2 for elaboration-time sizing
//  - entry_width : width of one buffered request {addr, wdata, wstrb}
package iob_wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no Wishbone cycle open
      ISSUE = 2'd1,   // cyc=stb=1, waiting for the strobe to be taken / terminated
      WAIT  = 2'd2    // pipelined only: strobe taken, cyc=1, waiting for termination
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r++;
      end
      return r;
   endfunction

   function automatic int entry_width(input int addr_w, input int data_w);
      return addr_w + data_w + data_w / 8;
   endfunction

endpackage

// File: rtl/iob_wb_bridge_if.sv
// Bus bundle between the CPU IOb interconnect and a Wishbone register slave.
//  slave  modport : the bridge's view (IOb slave on one side, Wishbone master on the other)
//  master modport : the environment's view (IOb requester plus Wishbone slave)
//  IOb      : s_valid, s_addr, s_wdata, s_wstrb -> s_ready, s_rvalid, s_rdata, s_rerr
//  Wishbone : wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
//             <- wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
interface iob_wb_bridge_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int WB_LSB = 2
);
   logic                     s_valid;
   logic [ADDR_W-1:0]        s_addr;
   logic [DATA_W-1:0]        s_wdata;
   logic [DATA_W/8-1:0]      s_wstrb;
   logic                     s_ready;
   logic                     s_rvalid;
   logic [DATA_W-1:0]        s_rdata;
   logic                     s_rerr;

   logic [ADDR_W-WB_LSB-1:0] wb_adr_o;
   logic [DATA_W-1:0]        wb_dat_o;
   logic [DATA_W/8-1:0]      wb_sel_o;
   logic                     wb_we_o;
   logic                     wb_cyc_o;
   logic                     wb_stb_o;
   logic [DATA_W-1:0]        wb_dat_i;
   logic                     wb_ack_i;
   logic                     wb_err_i;
   logic                     wb_stall_i;

   modport slave (
      input  s_valid, s_addr, s_wdata, s_wstrb,
      output s_ready, s_rvalid, s_rdata, s_rerr,
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
   );

   modport master (
      output s_valid, s_addr, s_wdata, s_wstrb,
      input  s_ready, s_rvalid, s_rdata, s_rerr,
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
   );
endinterface

// File: rtl/iob_wb_req_fifo.sv
// Register-based synchronous request FIFO.
//  push/push_data : write one entry (ignored when full)
//  pop            : drop the head entry (ignored when empty)
//  head_data      : current head entry
//  full/empty     : status from the current pointers
//  full_next      : full status after this cycle's push/pop, for a registered ready
// Pointers carry one extra wrap bit: full = MSBs differ and low bits equal.
module iob_wb_req_fifo
   import iob_wb_bridge_pkg::*;
#(
   parameter int WIDTH = 46,
   parameter int DEPTH = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic             full_next
);
   localparam int IW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
   localparam int PW = clog2(DEPTH) + 1;
   localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // A single-entry FIFO has no index bits; every pointer maps to slot 0.
   function automatic logic [IW-1:0] slot(input logic [PW-1:0] p);
      return (DEPTH == 1) ? '0 : p[IW-1:0];
   endfunction

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign head_data = mem_q[slot(rd_ptr_q)];

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d  = wr_ptr_q + PW'(do_push);
      rd_ptr_d  = rd_ptr_q + PW'(do_pop);
      full_next = ((wr_ptr_d ^ rd_ptr_d) == FULL_XOR);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which slots hold valid data.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[slot(wr_ptr_q)] <= push_data;
   end

endmodule

// File: rtl/iob_wb_bridge.sv
// IOb-native slave to Wishbone master bridge with request buffer, classic or
// pipelined (B4) mode, bus-timeout watchdog and error responses.
//  clk, rst_n : clock and asynchronous active-low reset
//  bus        : iob_wb_bridge_if.slave (IOb request/response + Wishbone master)
//  timeout_o  : one-cycle pulse when the watchdog aborts a Wishbone cycle
// One Wishbone cycle is outstanding at a time; responses return in order.
module iob_wb_bridge
   import iob_wb_bridge_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int WB_LSB    = 2,
   parameter int REQ_DEPTH = 2,
   parameter int PIPELINED = 0,
   parameter int TIMEOUT   = 255
)(
   input  logic             clk,
   input  logic             rst_n,
   iob_wb_bridge_if.slave   bus,
   output logic             timeout_o
);
   localparam int STRB_W  = DATA_W / 8;
   localparam int WADR_W  = ADDR_W - WB_LSB;
   localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);
   localparam int WDOG_W  = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [WADR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic [STRB_W-1:0]   sel_q, sel_d;
   logic                rvalid_q, rvalid_d, rerr_q, rerr_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                timeout_q, timeout_d, ready_q, ready_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;

   logic                push, pop, full, empty, full_next;
   logic                term, expire;
   logic [ENTRY_W-1:0]  push_entry, head_entry, src_entry;
   logic [STRB_W-1:0]   src_wstrb;
   logic                unused_addr_lsb;

   assign push       = bus.s_valid & ready_q;
   assign push_entry = {bus.s_addr, bus.s_wdata, bus.s_wstrb};
   // With an empty buffer the incoming request is issued in the same cycle it is
   // pushed, which gives the accept-at-T / strobe-at-T+1 latency.
   assign src_entry  = empty ? push_entry : head_entry;
   assign src_wstrb  = src_entry[STRB_W-1:0];
   // Byte-lane bits of the address are carried in the entry but never reach the bus.
   assign unused_addr_lsb = ^src_entry[ENTRY_W-WADR_W-1 -: WB_LSB];

   iob_wb_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (REQ_DEPTH)
   ) u_req_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .full      (full),
      .empty     (empty),
      .full_next (full_next)
   );

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      we_d      = we_q;
      wdog_d    = wdog_q;
      rvalid_d  = 1'b0;
      rdata_d   = '0;
      rerr_d    = 1'b0;
      timeout_d = 1'b0;
      pop       = 1'b0;
      // Ready is registered from the post-update fill level: no combinational
      // path from s_valid or the Wishbone inputs reaches s_ready.
      ready_d   = ~full_next;
      term      = bus.wb_ack_i | bus.wb_err_i;
      expire    = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

      case (state_q)
         IDLE: begin
            if (!empty || push) begin
               state_d = ISSUE;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               adr_d   = src_entry[ENTRY_W-1 -: WADR_W];
               dat_d   = src_entry[STRB_W +: DATA_W];
               we_d    = |src_wstrb;
               sel_d   = (|src_wstrb) ? src_wstrb : '1;
               wdog_d  = '0;
            end
         end
         ISSUE, WAIT: begin
            if (term) begin
               // err has priority over ack; a failed or write access returns zero data.
               state_d  = IDLE;
               cyc_d    = 1'b0;
               stb_d    = 1'b0;
               pop      = 1'b1;
               rvalid_d = 1'b1;
               rerr_d   = bus.wb_err_i;
               rdata_d  = (!bus.wb_err_i && !we_q) ? bus.wb_dat_i : '0;
            end else if (expire) begin
               state_d   = IDLE;
               cyc_d     = 1'b0;
               stb_d     = 1'b0;
               pop       = 1'b1;
               rvalid_d  = 1'b1;
               rerr_d    = 1'b1;
               timeout_d = 1'b1;
            end else begin
               if (TIMEOUT != 0) wdog_d = wdog_q + WDOG_W'(1);
               // Pipelined: the strobe is taken on the first non-stalled cycle.
               if ((PIPELINED != 0) && (state_q == ISSUE) && !bus.wb_stall_i) begin
                  stb_d   = 1'b0;
                  state_d = WAIT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         wdog_q    <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rerr_q    <= 1'b0;
         timeout_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
         wdog_q    <= wdog_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rerr_q    <= rerr_d;
         timeout_q <= timeout_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.s_ready  = ready_q;
   assign bus.s_rvalid = rvalid_q;
   assign bus.s_rdata  = rdata_q;
   assign bus.s_rerr   = rerr_q;
   assign bus.wb_adr_o = adr_q;
   assign bus.wb_dat_o = dat_q;
   assign bus.wb_sel_o = sel_q;
   assign bus.wb_we_o  = we_q;
   assign bus.wb_cyc_o = cyc_q;
   assign bus.wb_stb_o = stb_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_iob_wb_bridge.sv
// Directed bench for iob_wb_bridge: a classic instance (REQ_DEPTH=2, TIMEOUT=16)
// and a pipelined instance (PIPELINED=1, TIMEOUT=16) sharing clock and reset.
// Inputs change 1 ns after the rising edge; outputs are read at the same point.
module tb_iob_wb_bridge;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int WB_LSB = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic timeout_c, timeout_p;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   iob_wb_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_LSB(WB_LSB)) bus_c ();
   iob_wb_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_LSB(WB_LSB)) bus_p ();

   iob_wb_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_LSB(WB_LSB),
      .REQ_DEPTH(2), .PIPELINED(0), .TIMEOUT(16)
   ) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c), .timeout_o(timeout_c));

   iob_wb_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_LSB(WB_LSB),
      .REQ_DEPTH(2), .PIPELINED(1), .TIMEOUT(16)
   ) u_dut_p (.clk(clk), .rst_n(rst_n), .bus(bus_p), .timeout_o(timeout_p));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_c.s_valid = 0; bus_c.s_addr = '0; bus_c.s_wdata = '0; bus_c.s_wstrb = '0;
      bus_c.wb_dat_i = '0; bus_c.wb_ack_i = 0; bus_c.wb_err_i = 0; bus_c.wb_stall_i = 0;
      bus_p.s_valid = 0; bus_p.s_addr = '0; bus_p.s_wdata = '0; bus_p.s_wstrb = '0;
      bus_p.wb_dat_i = '0; bus_p.wb_ack_i = 0; bus_p.wb_err_i = 0; bus_p.wb_stall_i = 0;
   endtask

   task automatic request_c(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      bus_c.s_valid = 1; bus_c.s_addr = a; bus_c.s_wdata = d; bus_c.s_wstrb = s;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus_c.s_ready, bus_c.s_rvalid, bus_c.s_rerr, bus_c.wb_cyc_o, bus_c.wb_stb_o, bus_c.wb_we_o, timeout_c} !== 7'b0)
         begin errors++; $display("FAIL reset_ctrl: got %b want 0000000", {bus_c.s_ready, bus_c.s_rvalid, bus_c.s_rerr, bus_c.wb_cyc_o, bus_c.wb_stb_o, bus_c.wb_we_o, timeout_c}); end
      checks++;
      if (bus_c.wb_sel_o !== 4'h0 || bus_c.wb_adr_o !== 10'h0 || bus_c.s_rdata !== 32'h0)
         begin errors++; $display("FAIL reset_data: sel=%h adr=%h rdata=%h want all 0", bus_c.wb_sel_o, bus_c.wb_adr_o, bus_c.s_rdata); end
      rst_n = 1;
      step();
      checks++;
      if (bus_c.s_ready !== 1'b1 || bus_p.s_ready !== 1'b1)
         begin errors++; $display("FAIL reset_ready: got %b/%b want 1/1", bus_c.s_ready, bus_p.s_ready); end
   endtask

   task automatic test_classic_read();
      logic stb_ok;
      stb_ok = 1;
      request_c(12'h010, 32'h0, 4'h0);
      step();
      bus_c.s_valid = 0;
      checks++;
      if (bus_c.wb_cyc_o !== 1 || bus_c.wb_stb_o !== 1 || bus_c.wb_we_o !== 0)
         begin errors++; $display("FAIL rd_start: cyc/stb/we=%b%b%b want 110", bus_c.wb_cyc_o, bus_c.wb_stb_o, bus_c.wb_we_o); end
      checks++;
      if (bus_c.wb_adr_o !== 10'h004 || bus_c.wb_sel_o !== 4'hF)
         begin errors++; $display("FAIL rd_adr_sel: adr=%h sel=%h want 004 f", bus_c.wb_adr_o, bus_c.wb_sel_o); end
      repeat (3) begin
         step();
         if (bus_c.wb_stb_o !== 1 || bus_c.s_rvalid !== 0) stb_ok = 0;
      end
      checks++;
      if (!stb_ok) begin errors++; $display("FAIL rd_wait: stb dropped or early rvalid, got ok=%b want 1", stb_ok); end
      bus_c.wb_ack_i = 1; bus_c.wb_dat_i = 32'hDEADBEEF;
      step();
      bus_c.wb_ack_i = 0; bus_c.wb_dat_i = '0;
      checks++;
      if (bus_c.s_rvalid !== 1 || bus_c.s_rdata !== 32'hDEADBEEF || bus_c.s_rerr !== 0 || bus_c.wb_cyc_o !== 0)
         begin errors++; $display("FAIL rd_resp: rvalid=%b rdata=%h rerr=%b cyc=%b want 1 deadbeef 0 0", bus_c.s_rvalid, bus_c.s_rdata, bus_c.s_rerr, bus_c.wb_cyc_o); end
      step();
      checks++;
      if (bus_c.s_rvalid !== 0) begin errors++; $display("FAIL rd_pulse: rvalid=%b want 0", bus_c.s_rvalid); end
   endtask

   task automatic test_write();
      request_c(12'h020, 32'h12345678, 4'h3);
      step();
      bus_c.s_valid = 0;
      checks++;
      if (bus_c.wb_we_o !== 1 || bus_c.wb_sel_o !== 4'h3 || bus_c.wb_dat_o !== 32'h12345678 || bus_c.wb_adr_o !== 10'h008 || bus_c.wb_stb_o !== 1)
         begin errors++; $display("FAIL wr_bus: we=%b sel=%h dat=%h adr=%h stb=%b want 1 3 12345678 008 1", bus_c.wb_we_o, bus_c.wb_sel_o, bus_c.wb_dat_o, bus_c.wb_adr_o, bus_c.wb_stb_o); end
      bus_c.wb_ack_i = 1; bus_c.wb_dat_i = 32'hFFFFFFFF;
      step();
      bus_c.wb_ack_i = 0; bus_c.wb_dat_i = '0;
      checks++;
      if (bus_c.s_rvalid !== 1 || bus_c.s_rdata !== 32'h0 || bus_c.s_rerr !== 0)
         begin errors++; $display("FAIL wr_resp: rvalid=%b rdata=%h rerr=%b want 1 0 0", bus_c.s_rvalid, bus_c.s_rdata, bus_c.s_rerr); end
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] addrs [4];
      int   sent, got, acks, starts, wc, extra;
      logic prev_cyc, ready_checked, accept;
      logic [31:0] exp_d;
      addrs = '{12'h100, 12'h104, 12'h108, 12'h10C};
      sent = 0; got = 0; acks = 0; starts = 0; wc = 0; extra = 0;
      prev_cyc = 0; ready_checked = 0;
      for (int n = 0; n < 300 && got < 4; n++) begin
         if (bus_c.s_rvalid === 1'b1) begin
            exp_d = 32'hC0DE0000 | 32'(addrs[got]);
            checks++;
            if (bus_c.s_rdata !== exp_d || bus_c.s_rerr !== 0)
               begin errors++; $display("FAIL b2b_resp%0d: rdata=%h rerr=%b want %h 0", got, bus_c.s_rdata, bus_c.s_rerr, exp_d); end
            got++;
         end
         if (bus_c.wb_cyc_o && !prev_cyc) starts++;
         prev_cyc = bus_c.wb_cyc_o;
         if (sent < 4) request_c(addrs[sent], 32'h0, 4'h0);
         else bus_c.s_valid = 0;
         if (sent == 2 && !ready_checked) begin
            ready_checked = 1;
            checks++;
            if (bus_c.s_ready !== 0) begin errors++; $display("FAIL b2b_full: s_ready=%b want 0", bus_c.s_ready); end
         end
         accept = bus_c.s_valid && bus_c.s_ready;
         // Slave holds each strobe for 10 cycles; read data is derived from the address it sees.
         bus_c.wb_ack_i = 0;
         if (bus_c.wb_cyc_o && bus_c.wb_stb_o) begin
            if (wc == 10) begin
               bus_c.wb_ack_i = 1;
               bus_c.wb_dat_i = 32'hC0DE0000 | 32'({bus_c.wb_adr_o, 2'b00});
               if (acks < 4) begin
                  checks++;
                  if (bus_c.wb_adr_o !== addrs[acks][ADDR_W-1:WB_LSB])
                     begin errors++; $display("FAIL b2b_adr%0d: adr=%h want %h", acks, bus_c.wb_adr_o, addrs[acks][ADDR_W-1:WB_LSB]); end
               end
               acks++;
               wc = 0;
            end else wc++;
         end else wc = 0;
         step();
         if (accept) sent++;
      end
      idle_inputs();
      for (int n = 0; n < 20; n++) begin
         if (bus_c.s_rvalid || bus_c.wb_cyc_o) extra++;
         step();
      end
      checks++;
      if (got != 4 || acks != 4 || starts != 4 || extra != 0)
         begin errors++; $display("FAIL b2b_count: got=%0d acks=%0d starts=%0d extra=%0d want 4 4 4 0", got, acks, starts, extra); end
   endtask

   task automatic test_pipelined();
      int extra;
      extra = 0;
      bus_p.s_valid = 1; bus_p.s_addr = 12'h040; bus_p.s_wstrb = 4'h0;
      step();
      bus_p.s_valid = 0; bus_p.wb_stall_i = 1;
      checks++;
      if (bus_p.wb_cyc_o !== 1 || bus_p.wb_stb_o !== 1 || bus_p.wb_adr_o !== 10'h010)
         begin errors++; $display("FAIL pipe_start: cyc=%b stb=%b adr=%h want 1 1 010", bus_p.wb_cyc_o, bus_p.wb_stb_o, bus_p.wb_adr_o); end
      step();
      checks++;
      if (bus_p.wb_stb_o !== 1) begin errors++; $display("FAIL pipe_stall: stb=%b want 1", bus_p.wb_stb_o); end
      step();
      bus_p.wb_stall_i = 0;
      step();
      checks++;
      if (bus_p.wb_stb_o !== 0 || bus_p.wb_cyc_o !== 1)
         begin errors++; $display("FAIL pipe_wait: stb=%b cyc=%b want 0 1", bus_p.wb_stb_o, bus_p.wb_cyc_o); end
      step();
      bus_p.wb_ack_i = 1; bus_p.wb_dat_i = 32'hCAFEF00D;
      step();
      bus_p.wb_ack_i = 0; bus_p.wb_dat_i = '0;
      checks++;
      if (bus_p.s_rvalid !== 1 || bus_p.s_rdata !== 32'hCAFEF00D || bus_p.wb_cyc_o !== 0)
         begin errors++; $display("FAIL pipe_resp: rvalid=%b rdata=%h cyc=%b want 1 cafef00d 0", bus_p.s_rvalid, bus_p.s_rdata, bus_p.wb_cyc_o); end
      for (int n = 0; n < 10; n++) begin
         step();
         if (bus_p.s_rvalid || bus_p.wb_cyc_o) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL pipe_single: extra=%0d want 0", extra); end
   endtask

   task automatic test_timeout();
      int n, late;
      n = 0; late = 0;
      request_c(12'h0F0, 32'h0, 4'h0);
      step();
      bus_c.s_valid = 0;
      while (bus_c.wb_cyc_o === 1'b1 && n < 40) begin
         if (timeout_c !== 0) late++;
         n++;
         step();
      end
      checks++;
      if (n != 16 || late != 0) begin errors++; $display("FAIL to_len: cyc cycles=%0d early_to=%0d want 16 0", n, late); end
      checks++;
      if (timeout_c !== 1 || bus_c.s_rvalid !== 1 || bus_c.s_rerr !== 1 || bus_c.s_rdata !== 32'h0)
         begin errors++; $display("FAIL to_resp: to=%b rvalid=%b rerr=%b rdata=%h want 1 1 1 0", timeout_c, bus_c.s_rvalid, bus_c.s_rerr, bus_c.s_rdata); end
      bus_c.wb_ack_i = 1; bus_c.wb_dat_i = 32'h77777777;
      for (int k = 0; k < 3; k++) begin
         step();
         if (bus_c.s_rvalid || timeout_c || bus_c.wb_cyc_o) late++;
      end
      bus_c.wb_ack_i = 0; bus_c.wb_dat_i = '0;
      checks++;
      if (late != 0) begin errors++; $display("FAIL to_late_ack: responses=%0d want 0", late); end
   endtask

   task automatic test_timeout_ack_race();
      request_c(12'h0A0, 32'h0, 4'h0);
      step();
      bus_c.s_valid = 0;
      repeat (15) step();
      checks++;
      if (bus_c.wb_cyc_o !== 1) begin errors++; $display("FAIL race_cyc: cyc=%b want 1", bus_c.wb_cyc_o); end
      bus_c.wb_ack_i = 1; bus_c.wb_dat_i = 32'h5A5A5A5A;
      step();
      bus_c.wb_ack_i = 0; bus_c.wb_dat_i = '0;
      checks++;
      if (bus_c.s_rvalid !== 1 || bus_c.s_rerr !== 0 || bus_c.s_rdata !== 32'h5A5A5A5A || timeout_c !== 0)
         begin errors++; $display("FAIL race_resp: rvalid=%b rerr=%b rdata=%h to=%b want 1 0 5a5a5a5a 0", bus_c.s_rvalid, bus_c.s_rerr, bus_c.s_rdata, timeout_c); end
   endtask

   task automatic test_ack_err();
      request_c(12'h030, 32'h0, 4'h0);
      step();
      bus_c.s_valid = 0;
      bus_c.wb_ack_i = 1; bus_c.wb_err_i = 1; bus_c.wb_dat_i = 32'h11111111;
      step();
      bus_c.wb_ack_i = 0; bus_c.wb_err_i = 0; bus_c.wb_dat_i = '0;
      checks++;
      if (bus_c.s_rvalid !== 1 || bus_c.s_rerr !== 1 || bus_c.s_rdata !== 32'h0 || timeout_c !== 0)
         begin errors++; $display("FAIL ackerr_resp: rvalid=%b rerr=%b rdata=%h to=%b want 1 1 0 0", bus_c.s_rvalid, bus_c.s_rerr, bus_c.s_rdata, timeout_c); end
   endtask

   task automatic test_reset_mid_cycle();
      int seen;
      seen = 0;
      request_c(12'h0C0, 32'h0, 4'h0);
      step();
      request_c(12'h0C4, 32'h0, 4'h0);
      step();
      bus_c.s_valid = 0;
      checks++;
      if (bus_c.wb_cyc_o !== 1) begin errors++; $display("FAIL rst_pre: cyc=%b want 1", bus_c.wb_cyc_o); end
      rst_n = 0;
      #1;
      checks++;
      if (bus_c.wb_cyc_o !== 0 || bus_c.wb_stb_o !== 0 || bus_c.s_ready !== 0)
         begin errors++; $display("FAIL rst_async: cyc=%b stb=%b ready=%b want 0 0 0", bus_c.wb_cyc_o, bus_c.wb_stb_o, bus_c.s_ready); end
      repeat (3) begin
         step();
         if (bus_c.s_rvalid) seen++;
      end
      rst_n = 1;
      step();
      checks++;
      if (bus_c.s_ready !== 1) begin errors++; $display("FAIL rst_ready: ready=%b want 1", bus_c.s_ready); end
      repeat (10) begin
         if (bus_c.s_rvalid || bus_c.wb_cyc_o) seen++;
         step();
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rst_discard: activity=%0d want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_classic_read();
      repeat (2) step();
      test_write();
      repeat (2) step();
      test_back_to_back();
      test_pipelined();
      repeat (2) step();
      test_timeout();
      repeat (2) step();
      test_timeout_ack_race();
      repeat (2) step();
      test_ack_err();
      repeat (2) step();
      test_reset_mid_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
